// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder: HD44780-style 8-bit bus responder holding a
// 2-line character buffer, used as an on-chip display model.
module lcd_bus_responder #(
  parameter int LINE_LEN     = 16,
  parameter int BUSY_CYCLES  = 50,
  parameter int CLEAR_CYCLES = 2000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_E,
  input  logic                          i_RS,
  input  logic                          i_RW,
  input  logic [7:0]                    i_data,
  output logic [7:0]                    o_r_data,
  output logic                          o_r_oe,
  input  logic [$clog2(2*LINE_LEN)-1:0] i_rd_addr,
  output logic [7:0]                    o_r_rd_char,
  output logic                          o_r_busy,
  output logic [6:0]                    o_r_ac,
  output logic [2:0]                    o_r_disp_ctrl,
  output logic                          o_r_wr_stb,
  output logic                          o_r_err
);

  localparam int DEPTH = 2*LINE_LEN;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(CLEAR_CYCLES+1);
  localparam int FILL_REM =
    (CLEAR_CYCLES > DEPTH) ? CLEAR_CYCLES-DEPTH-1 : 0;

  localparam logic [CW-1:0] BUSY_LD  = CW'(BUSY_CYCLES-1);
  localparam logic [CW-1:0] CLEAR_LD = CW'(CLEAR_CYCLES-1);
  localparam logic [CW-1:0] FILL_LD  = CW'(FILL_REM);
  localparam logic [5:0]    LAST_COL = 6'(LINE_LEN-1);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH-1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_FILL
  } state_t;

  function automatic logic [6:0] ac_inc(input logic [6:0] ac);
    if (ac[5:0] == LAST_COL) return ac[6] ? 7'h00 : 7'h40;
    return ac + 7'd1;
  endfunction

  function automatic logic [6:0] ac_dec(input logic [6:0] ac);
    if (ac[5:0] == 6'd0) return {~ac[6], LAST_COL};
    return ac - 7'd1;
  endfunction

  logic [SYNC_STAGES-1:0] r_e_sync;
  logic [SYNC_STAGES-1:0] r_rs_sync;
  logic [SYNC_STAGES-1:0] r_rw_sync;
  logic [7:0]             r_d_sync [SYNC_STAGES];
  logic                   r_e_prev;
  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [AW-1:0]          r_fill_idx;
  logic                   r_id;
  logic                   r_rs_l;
  logic                   r_rw_l;
  logic                   r_rd_ok;
  logic [7:0]             r_buf [DEPTH];

  logic          w_e;
  logic          w_rs;
  logic          w_rw;
  logic [7:0]    w_d;
  logic          w_rise;
  logic          w_fall;
  logic          w_busy;
  logic [AW-1:0] w_ac_idx;

  state_t        w_state_nx;
  logic [CW-1:0] w_cnt_nx;
  logic [AW-1:0] w_fill_nx;
  logic [6:0]    w_ac_nx;
  logic          w_id_nx;
  logic [2:0]    w_dc_nx;
  logic [7:0]    w_data_nx;
  logic          w_oe_nx;
  logic          w_stb_nx;
  logic          w_err_nx;
  logic          w_rd_ok_nx;
  logic          w_rs_l_nx;
  logic          w_rw_l_nx;
  logic          w_go_busy;
  logic          w_we;
  logic [AW-1:0] w_widx;
  logic [7:0]    w_wdat;

  assign w_e    = r_e_sync[SYNC_STAGES-1];
  assign w_rs   = r_rs_sync[SYNC_STAGES-1];
  assign w_rw   = r_rw_sync[SYNC_STAGES-1];
  assign w_d    = r_d_sync[SYNC_STAGES-1];
  assign w_rise = w_e & ~r_e_prev;
  assign w_fall = ~w_e & r_e_prev;
  assign w_busy = (r_state != S_IDLE);

  assign w_ac_idx = o_r_ac[6]
    ? AW'(LINE_LEN) + AW'(o_r_ac[5:0])
    : AW'(o_r_ac[5:0]);

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_fill_nx  = r_fill_idx;
    w_ac_nx    = o_r_ac;
    w_id_nx    = r_id;
    w_dc_nx    = o_r_disp_ctrl;
    w_data_nx  = o_r_data;
    w_oe_nx    = o_r_oe;
    w_stb_nx   = 1'b0;
    w_err_nx   = 1'b0;
    w_rd_ok_nx = r_rd_ok;
    w_rs_l_nx  = r_rs_l;
    w_rw_l_nx  = r_rw_l;
    w_go_busy  = 1'b0;
    w_we       = 1'b0;
    w_widx     = w_ac_idx;
    w_wdat     = w_d;

    unique case (r_state)
      S_FILL: begin
        w_we   = 1'b1;
        w_widx = r_fill_idx;
        w_wdat = 8'h20;
        if (r_fill_idx == LAST_IDX) begin
          w_state_nx = S_EXEC;
          w_cnt_nx   = FILL_LD;
        end else begin
          w_fill_nx = r_fill_idx + AW'(1);
        end
      end
      S_EXEC: begin
        if (r_cnt == '0) w_state_nx = S_IDLE;
        else             w_cnt_nx   = r_cnt - CW'(1);
      end
      default: ;
    endcase

    if (w_rise) begin
      w_rs_l_nx = w_rs;
      w_rw_l_nx = w_rw;
      if (w_rw) begin
        w_oe_nx = 1'b1;
        if (!w_rs) begin
          w_data_nx = {w_busy, o_r_ac};
        end else if (w_busy) begin
          w_data_nx  = 8'hFF;
          w_err_nx   = 1'b1;
          w_rd_ok_nx = 1'b0;
        end else begin
          w_data_nx  = r_buf[w_ac_idx];
          w_rd_ok_nx = 1'b1;
        end
      end
    end

    if (w_fall) begin
      w_oe_nx = 1'b0;
      if (r_rw_l) begin
        if (r_rs_l && r_rd_ok)
          w_ac_nx = r_id ? ac_inc(o_r_ac) : ac_dec(o_r_ac);
        w_rd_ok_nx = 1'b0;
      end else if (w_busy) begin
        w_err_nx = 1'b1;
      end else if (r_rs_l) begin
        w_we      = 1'b1;
        w_ac_nx   = r_id ? ac_inc(o_r_ac) : ac_dec(o_r_ac);
        w_go_busy = 1'b1;
      end else begin
        unique casez (w_d)
          8'b1???????: begin
            w_go_busy = 1'b1;
            if (w_d[5:0] > LAST_COL) begin
              // Off-screen column snaps to the start of that line
              w_ac_nx  = {w_d[6], 6'd0};
              w_err_nx = 1'b1;
            end else begin
              w_ac_nx = w_d[6:0];
            end
          end
          8'b01??????: w_err_nx = 1'b1;
          8'b001?????: begin
            if (!w_d[4]) w_err_nx  = 1'b1;
            else         w_go_busy = 1'b1;
          end
          8'b0001????: begin
            w_go_busy = 1'b1;
            if (!w_d[3])
              w_ac_nx = w_d[2] ? ac_inc(o_r_ac) : ac_dec(o_r_ac);
          end
          8'b00001???: begin
            w_go_busy = 1'b1;
            w_dc_nx   = w_d[2:0];
          end
          8'b000001??: begin
            w_go_busy = 1'b1;
            w_id_nx   = w_d[1];
          end
          8'b0000001?: begin
            w_stb_nx   = 1'b1;
            w_ac_nx    = 7'h00;
            w_state_nx = S_EXEC;
            w_cnt_nx   = CLEAR_LD;
          end
          8'b00000001: begin
            w_stb_nx   = 1'b1;
            w_ac_nx    = 7'h00;
            w_id_nx    = 1'b1;
            w_state_nx = S_FILL;
            w_fill_nx  = '0;
          end
          default: ;
        endcase
      end
      if (w_go_busy) begin
        w_stb_nx   = 1'b1;
        w_state_nx = S_EXEC;
        w_cnt_nx   = BUSY_LD;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_e_sync      <= '0;
      r_rs_sync     <= '0;
      r_rw_sync     <= '0;
      for (int k = 0; k < SYNC_STAGES; k++) r_d_sync[k] <= 8'h00;
      r_e_prev      <= 1'b0;
      r_state       <= S_FILL;
      r_cnt         <= '0;
      r_fill_idx    <= '0;
      r_id          <= 1'b1;
      r_rs_l        <= 1'b0;
      r_rw_l        <= 1'b0;
      r_rd_ok       <= 1'b0;
      o_r_ac        <= 7'h00;
      o_r_disp_ctrl <= 3'b000;
      o_r_data      <= 8'h00;
      o_r_oe        <= 1'b0;
      o_r_wr_stb    <= 1'b0;
      o_r_err       <= 1'b0;
      o_r_busy      <= 1'b1;
    end else begin
      r_e_sync  <= {r_e_sync[SYNC_STAGES-2:0], i_E};
      r_rs_sync <= {r_rs_sync[SYNC_STAGES-2:0], i_RS};
      r_rw_sync <= {r_rw_sync[SYNC_STAGES-2:0], i_RW};
      r_d_sync[0] <= i_data;
      for (int k = 1; k < SYNC_STAGES; k++)
        r_d_sync[k] <= r_d_sync[k-1];
      r_e_prev      <= w_e;
      r_state       <= w_state_nx;
      r_cnt         <= w_cnt_nx;
      r_fill_idx    <= w_fill_nx;
      r_id          <= w_id_nx;
      r_rs_l        <= w_rs_l_nx;
      r_rw_l        <= w_rw_l_nx;
      r_rd_ok       <= w_rd_ok_nx;
      o_r_ac        <= w_ac_nx;
      o_r_disp_ctrl <= w_dc_nx;
      o_r_data      <= w_data_nx;
      o_r_oe        <= w_oe_nx;
      o_r_wr_stb    <= w_stb_nx;
      o_r_err       <= w_err_nx;
      o_r_busy      <= (w_state_nx != S_IDLE);
    end
  end

  // Buffer content survives reset; FILL rewrites it afterwards
  always_ff @(posedge i_clk) begin
    if (w_we) r_buf[w_widx] <= w_wdat;
    o_r_rd_char <= r_buf[i_rd_addr];
  end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// tb_lcd_bus_responder: directed bus transactions checked against a
// queue of expected read data, strobes, errors and probe values.
module tb_lcd_bus_responder;

  localparam int LINE_LEN     = 16;
  localparam int BUSY_CYCLES  = 50;
  localparam int CLEAR_CYCLES = 2000;
  localparam int AW           = $clog2(2*LINE_LEN);

  localparam int K_RD  = 0;
  localparam int K_ERR = 1;
  localparam int K_STB = 2;
  localparam int K_PRB = 3;

  localparam int P_BUSY = 0;
  localparam int P_AC   = 1;
  localparam int P_CHR  = 2;
  localparam int P_DC   = 3;
  localparam int P_OE   = 4;

  logic          clk = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_E = 1'b0;
  logic          i_RS = 1'b0;
  logic          i_RW = 1'b0;
  logic [7:0]    i_data = 8'h00;
  logic [AW-1:0] i_rd_addr = '0;
  logic [7:0]    o_r_data;
  logic          o_r_oe;
  logic [7:0]    o_r_rd_char;
  logic          o_r_busy;
  logic [6:0]    o_r_ac;
  logic [2:0]    o_r_disp_ctrl;
  logic          o_r_wr_stb;
  logic          o_r_err;

  int    sb_k[$];
  int    sb_v[$];
  string sb_n[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic  oe_q = 1'b0;
  logic  probe = 1'b0;
  int    probe_sel = 0;

  always #5 clk = ~clk;

  lcd_bus_responder #(
    .LINE_LEN(LINE_LEN),
    .BUSY_CYCLES(BUSY_CYCLES),
    .CLEAR_CYCLES(CLEAR_CYCLES),
    .SYNC_STAGES(2)
  ) dut (
    .i_clk(clk),
    .i_reset(i_reset),
    .i_E(i_E),
    .i_RS(i_RS),
    .i_RW(i_RW),
    .i_data(i_data),
    .o_r_data(o_r_data),
    .o_r_oe(o_r_oe),
    .i_rd_addr(i_rd_addr),
    .o_r_rd_char(o_r_rd_char),
    .o_r_busy(o_r_busy),
    .o_r_ac(o_r_ac),
    .o_r_disp_ctrl(o_r_disp_ctrl),
    .o_r_wr_stb(o_r_wr_stb),
    .o_r_err(o_r_err)
  );

  function automatic int probe_val();
    case (probe_sel)
      P_BUSY:  return int'(o_r_busy);
      P_AC:    return int'(o_r_ac);
      P_CHR:   return int'(o_r_rd_char);
      P_DC:    return int'(o_r_disp_ctrl);
      default: return int'(o_r_oe);
    endcase
  endfunction

  task automatic sb_check(input int kind, input int got);
    int ek;
    int ev;
    string nm;
    n_cmp++;
    if (sb_k.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected event kind %0d value 0x%0h, required none",
               kind, got);
    end else begin
      ek = sb_k.pop_front();
      ev = sb_v.pop_front();
      nm = sb_n.pop_front();
      if (ek != kind || ev != got) begin
        n_bad++;
        $display("FAIL %s: got kind %0d value 0x%0h, required kind %0d value 0x%0h",
                 nm, kind, got, ek, ev);
      end
    end
  endtask

  // Monitor: one pass per cycle, fixed order RD, ERR, STB, probe
  always @(negedge clk) begin
    if (o_r_oe && !oe_q) sb_check(K_RD, int'(o_r_data));
    if (o_r_err)         sb_check(K_ERR, 0);
    if (o_r_wr_stb)      sb_check(K_STB, 0);
    if (probe)           sb_check(K_PRB, probe_val());
    oe_q = o_r_oe;
  end

  task automatic push(input int k, input int v, input string nm);
    sb_k.push_back(k);
    sb_v.push_back(v);
    sb_n.push_back(nm);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic rs, input logic rw, input logic [7:0] d);
    i_RS = rs;
    i_RW = rw;
    i_data = d;
    tick(1);
    i_E = 1'b1;
    tick(6);
    i_E = 1'b0;
    tick(6);
  endtask

  // ev bit0: write strobe expected, bit1: error pulse expected
  task automatic wr(input logic rs, input logic [7:0] d,
                    input int ev, input string nm);
    if (ev[1]) push(K_ERR, 0, {nm, " err"});
    if (ev[0]) push(K_STB, 0, {nm, " stb"});
    bus(rs, 1'b0, d);
  endtask

  task automatic wait_idle(input int bound, input string nm);
    int n = 0;
    while (o_r_busy && n < bound) begin
      tick(1);
      n++;
    end
    if (o_r_busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: busy still 1 after %0d cycles, required 0", nm, bound);
    end
    tick(1);
  endtask

  task automatic wr_w(input logic rs, input logic [7:0] d, input string nm);
    wr(rs, d, 1, nm);
    wait_idle(BUSY_CYCLES + 20, nm);
  endtask

  task automatic rd(input logic rs, input int exp, input logic err,
                    input string nm);
    push(K_RD, exp, nm);
    if (err) push(K_ERR, 0, {nm, " err"});
    bus(rs, 1'b1, 8'h00);
  endtask

  task automatic prb(input int sel, input int addr, input int exp,
                     input string nm);
    i_rd_addr = AW'(addr);
    probe_sel = sel;
    tick(1);
    push(K_PRB, exp, nm);
    probe = 1'b1;
    tick(1);
    probe = 1'b0;
  endtask

  task automatic measure_busy(input string nm);
    int n = 0;
    while (o_r_busy && n < CLEAR_CYCLES + 200) begin
      n++;
      tick(1);
    end
    n_cmp++;
    if (n != CLEAR_CYCLES) begin
      n_bad++;
      $display("FAIL %s: busy lasted %0d cycles, required %0d",
               nm, n, CLEAR_CYCLES);
    end
  endtask

  initial begin
    tick(2);
    prb(P_BUSY, 0, 1, "reset busy");
    prb(P_AC,   0, 0, "reset ac");
    prb(P_DC,   0, 0, "reset disp_ctrl");
    prb(P_OE,   0, 0, "reset oe");
    i_reset = 1'b1;
    measure_busy("power-up fill busy");
    for (int a = 0; a < 2*LINE_LEN; a++)
      prb(P_CHR, a, 8'h20, $sformatf("fill slot %0d", a));
    prb(P_AC, 0, 0, "ac after fill");

    wr_w(0, 8'h80, "set ac 0");
    wr_w(1, 8'h41, "data A");
    wr_w(1, 8'h42, "data B");
    prb(P_CHR, 0, 8'h41, "slot0");
    prb(P_CHR, 1, 8'h42, "slot1");
    prb(P_AC,  0, 8'h02, "ac after AB");

    wr_w(0, 8'h8F, "set ac 0x0F");
    wr_w(1, 8'h5A, "data 5A");
    prb(P_AC, 0, 8'h40, "line0 wrap");
    wr_w(1, 8'h5B, "data 5B");
    prb(P_CHR, 15, 8'h5A, "slot15");
    prb(P_CHR, 16, 8'h5B, "slot16");
    prb(P_AC,  0, 8'h41, "ac 0x41");

    wr(1, 8'h43, 1, "data 43");
    rd(0, 8'hC2, 0, "status busy");
    wait_idle(BUSY_CYCLES + 20, "after 43");
    rd(0, 8'h42, 0, "status idle");
    rd(1, 8'h20, 0, "data read slot18");
    rd(0, 8'h43, 0, "status after data read");

    wr(1, 8'h44, 1, "data 44");
    wr(1, 8'h55, 2, "write while busy");
    rd(1, 8'hFF, 1, "data read while busy");
    wait_idle(BUSY_CYCLES + 20, "after 44");
    prb(P_CHR, 19, 8'h44, "slot19");
    prb(P_CHR, 20, 8'h20, "slot20 unchanged");
    prb(P_AC,  0, 8'h44, "ac held");
    wr(0, 8'h40, 2, "cgram");
    prb(P_BUSY, 0, 0, "cgram no busy");

    wr_w(0, 8'h0E, "display ctrl");
    prb(P_DC, 0, 6, "disp_ctrl 110");
    wr(0, 8'h20, 2, "function set DL=0");
    prb(P_BUSY, 0, 0, "DL=0 no busy");
    wr_w(0, 8'h38, "function set DL=1");
    wr(0, 8'h00, 0, "no-op");
    prb(P_BUSY, 0, 0, "no-op no busy");
    wr(0, 8'h95, 3, "set ac off-screen");
    wait_idle(BUSY_CYCLES + 20, "after 0x95");
    prb(P_AC, 0, 8'h00, "off-screen col 0");

    wr_w(0, 8'hCF, "set ac 0x4F");
    wr_w(0, 8'h14, "shift right");
    prb(P_AC, 0, 8'h00, "line1 wrap");
    wr_w(0, 8'h10, "shift left");
    prb(P_AC, 0, 8'h4F, "reverse wrap");
    wr_w(0, 8'h18, "display shift");
    prb(P_AC, 0, 8'h4F, "display shift no ac");

    wr_w(0, 8'h04, "entry decrement");
    wr_w(0, 8'hC0, "set ac 0x40");
    wr_w(1, 8'h31, "data 31");
    prb(P_CHR, 16, 8'h31, "slot16 31");
    prb(P_AC,  0, 8'h0F, "dec wrap 0x40");
    wr_w(1, 8'h32, "data 32");
    prb(P_CHR, 15, 8'h32, "slot15 32");
    prb(P_AC,  0, 8'h0E, "dec 0x0E");
    wr(0, 8'h02, 1, "return home");
    prb(P_AC,   0, 0, "home ac");
    prb(P_BUSY, 0, 1, "home busy");
    wait_idle(CLEAR_CYCLES + 100, "home");

    wr_w(0, 8'hCF, "set ac 0x4F again");
    wr_w(1, 8'h77, "data 77");
    prb(P_CHR, 31, 8'h77, "slot31 77");
    prb(P_AC,  0, 8'h4E, "ac 0x4E");
    wr(0, 8'h01, 1, "clear");
    i_reset = 1'b0;
    prb(P_BUSY, 0, 1, "mid-fill reset busy");
    prb(P_AC,   0, 0, "mid-fill reset ac");
    i_reset = 1'b1;
    measure_busy("restart fill busy");
    prb(P_CHR, 31, 8'h20, "slot31 cleared");
    prb(P_CHR, 16, 8'h20, "slot16 cleared");
    prb(P_AC,  0, 0, "ac after restart");
    wr_w(1, 8'h61, "data 61");
    prb(P_AC,  0, 1, "increment restored");
    prb(P_CHR, 0, 8'h61, "slot0 61");

    tick(5);
    while (sb_k.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: never observed, required kind %0d value 0x%0h",
               sb_n[0], sb_k[0], sb_v[0]);
      void'(sb_k.pop_front());
      void'(sb_v.pop_front());
      void'(sb_n.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
